// File: rtl/tl_pkg.sv
// Shared definitions for the two-road traffic light controller.
// Holds the phase encodings reported on the phase output and the
// {R,Y,G} lamp patterns driven onto lamp_a / lamp_b.
package tl_pkg;

  // Phase encodings are visible on the phase output, so values are fixed.
  // Encoding 7 is unused and is recovered to ALLRED_BA by the controller.
  typedef enum logic [2:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALLRED_AB = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALLRED_BA = 3'd5,
    FLASH     = 3'd6
  } phase_t;

  // Lamp patterns, bit order {R,Y,G}.
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/tl_dwell_timer.sv
// Purpose: loadable down-counter measuring how long a phase has dwelt; saturates at 0.
// Latency: load or decrement visible one cycle after the enabled edge; zero is combinational on count.
// Backpressure: none; en=0 freezes the count, load takes priority over decrement.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-low reset (count <= RST_VAL)
//   en            step enable; count only changes on edges with en=1
//   load          reload count with load_val on the next enabled edge
//   load_val[W]   value to load
//   count[W]      current count remaining
//   zero          count == 0
module tl_dwell_timer #(
  parameter int W       = 8,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= W'(RST_VAL);
    end else if (en) begin
      if (load) begin
        count_q <= load_val;
      end else if (count_q != '0) begin
        count_q <= count_q - W'(1);
      end
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Purpose: two-road intersection phase sequencer with side-road demand and maintenance flash.
// Latency: phase/timer update on the enabled edge; lamps decode registered state in the same cycle; phase_done one cycle after a transition.
// Backpressure: none; en=0 holds all state and forces phase_done low.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset (A_GREEN, full A dwell)
//   en              step enable
//   req_b           level: vehicle waiting on road B (only consulted in A_GREEN)
//   maint           maintenance request: flashing yellow on both roads
//   lamp_a, lamp_b  {R,Y,G} lamp drive for road A / road B
//   phase           current phase encoding (tl_pkg::phase_t)
//   timer[W]        dwell count remaining in the current phase
//   phase_done      pulses for one cycle after any phase transition
module traffic_light_ctrl
  import tl_pkg::*;
#(
  parameter int W             = 8,
  parameter int A_GREEN_TICKS = 8,
  parameter int B_GREEN_TICKS = 6,
  parameter int YELLOW_TICKS  = 3,
  parameter int ALLRED_TICKS  = 2,
  parameter int FLASH_TICKS   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         req_b,
  input  logic         maint,
  output logic [2:0]   lamp_a,
  output logic [2:0]   lamp_b,
  output logic [2:0]   phase,
  output logic [W-1:0] timer,
  output logic         phase_done
);

  // Reload values: a phase lasting N enabled cycles loads N-1.
  localparam logic [W-1:0] LD_A_GREEN = W'(A_GREEN_TICKS - 1);
  localparam logic [W-1:0] LD_B_GREEN = W'(B_GREEN_TICKS - 1);
  localparam logic [W-1:0] LD_YELLOW  = W'(YELLOW_TICKS - 1);
  localparam logic [W-1:0] LD_ALLRED  = W'(ALLRED_TICKS - 1);
  localparam logic [W-1:0] LD_FLASH   = W'(FLASH_TICKS - 1);

  phase_t       state_q, state_d;
  logic         flash_on_q, flash_on_d;
  logic         phase_done_q;
  logic         take;
  logic         load;
  logic [W-1:0] load_val;
  logic         zero;

  tl_dwell_timer #(
    .W       (W),
    .RST_VAL (A_GREEN_TICKS - 1)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .count    (timer),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= A_GREEN;
      flash_on_q   <= 1'b0;
      phase_done_q <= 1'b0;
    end else begin
      phase_done_q <= en & take;
      if (en) begin
        state_q    <= state_d;
        flash_on_q <= flash_on_d;
      end
    end
  end

  // Next state. take marks a real phase change (drives phase_done);
  // a flash toggle reloads the timer but is not a transition.
  always_comb begin
    state_d    = state_q;
    flash_on_d = flash_on_q;
    take       = 1'b0;
    load       = 1'b0;
    load_val   = '0;

    case (state_q)
      A_GREEN: begin
        if (zero && req_b) begin
          state_d  = A_YELLOW;
          load     = 1'b1;
          load_val = LD_YELLOW;
          take     = 1'b1;
        end
      end
      A_YELLOW: begin
        if (zero) begin
          state_d  = ALLRED_AB;
          load     = 1'b1;
          load_val = LD_ALLRED;
          take     = 1'b1;
        end
      end
      ALLRED_AB: begin
        if (zero) begin
          state_d  = B_GREEN;
          load     = 1'b1;
          load_val = LD_B_GREEN;
          take     = 1'b1;
        end
      end
      B_GREEN: begin
        if (zero) begin
          state_d  = B_YELLOW;
          load     = 1'b1;
          load_val = LD_YELLOW;
          take     = 1'b1;
        end
      end
      B_YELLOW: begin
        if (zero) begin
          state_d  = ALLRED_BA;
          load     = 1'b1;
          load_val = LD_ALLRED;
          take     = 1'b1;
        end
      end
      ALLRED_BA: begin
        if (zero) begin
          state_d  = A_GREEN;
          load     = 1'b1;
          load_val = LD_A_GREEN;
          take     = 1'b1;
        end
      end
      FLASH: begin
        // Leaving maintenance does not wait for the flash half-period.
        if (!maint) begin
          state_d    = ALLRED_BA;
          load       = 1'b1;
          load_val   = LD_ALLRED;
          flash_on_d = 1'b0;
          take       = 1'b1;
        end else if (zero) begin
          load       = 1'b1;
          load_val   = LD_FLASH;
          flash_on_d = ~flash_on_q;
        end
      end
      default: begin
        // Unused encoding: fall back to a safe all-red clearance.
        state_d  = ALLRED_BA;
        load     = 1'b1;
        load_val = LD_ALLRED;
        take     = 1'b1;
      end
    endcase

    // Maintenance overrides every other exit from a non-flash phase.
    if (maint && state_q != FLASH) begin
      state_d    = FLASH;
      load       = 1'b1;
      load_val   = LD_FLASH;
      flash_on_d = 1'b1;
      take       = 1'b1;
    end
  end

  // Lamp decode from registered state only.
  always_comb begin
    lamp_a = LAMP_R;
    lamp_b = LAMP_R;
    case (state_q)
      A_GREEN:  lamp_a = LAMP_G;
      A_YELLOW: lamp_a = LAMP_Y;
      B_GREEN:  lamp_b = LAMP_G;
      B_YELLOW: lamp_b = LAMP_Y;
      FLASH: begin
        lamp_a = flash_on_q ? LAMP_Y : LAMP_OFF;
        lamp_b = flash_on_q ? LAMP_Y : LAMP_OFF;
      end
      default: ;
    endcase
  end

  assign phase      = state_q;
  assign phase_done = phase_done_q;

endmodule
